// File: rtl/mul_norm_seq.sv
// ---------------------------------------------------------------------------
// mul_norm_seq
// Multi-cycle normaliser for the floating-point multiplier datapath. Takes
// the raw 2*MW-bit mantissa product and the biased exponent sum, and
// returns a product whose leading one sits at bit PW-2. The exponent is
// adjusted to match. Left shifts are applied iteratively, at most
// SHIFT_STEP positions per cycle, so the shifter stays narrow.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand valid          in_ready   block can accept an operand
//   in_e       biased exponent sum    in_m       raw mantissa product
//   out_valid  result valid           out_ready  downstream accepts result
//   out_e      adjusted exponent      out_m      normalised mantissa
//   out_zero   product was zero       out_ovf    exponent overflow
//   out_unf    exponent underflow
// ---------------------------------------------------------------------------
module mul_norm_seq #(
    parameter int MW         = 24,
    parameter int EW         = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW-1:0]       in_e,
    input  logic [2*MW-1:0]     in_m,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW-1:0]       out_e,
    output logic [2*MW-1:0]     out_m,
    output logic                out_zero,
    output logic                out_ovf,
    output logic                out_unf
);

    localparam int PW = 2 * MW;
    localparam int KW = $clog2(SHIFT_STEP + 1);
    // Largest exponent that is still representable is one below all-ones.
    localparam logic [EW+1:0] E_MAX = {2'b00, {EW{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_m;
    logic [EW+1:0]   r_e;      // two's complement, EW+2 bits
    logic            r_zero;
    logic            r_out_valid;
    logic [EW-1:0]   r_out_e;
    logic [PW-1:0]   r_out_m;
    logic            r_out_zero;
    logic            r_out_ovf;
    logic            r_out_unf;

    logic [KW-1:0]   w_k;
    logic [EW+1:0]   w_k_ext;
    logic            w_ovf;
    logic            w_unf;

    // Shift amount for one NORM step: leading-zero count below bit PW-2,
    // capped at SHIFT_STEP. Only the top SHIFT_STEP bits need inspecting,
    // because any longer run is clipped to SHIFT_STEP anyway.
    always_comb begin
        w_k = KW'(SHIFT_STEP);
        for (int j = SHIFT_STEP - 1; j >= 0; j--) begin
            w_k = r_m[PW-2-j] ? KW'(j) : w_k;
        end
    end

    assign w_k_ext = (EW+2)'(w_k);

    // Exponent range classification of the final internal exponent.
    assign w_ovf = (r_e[EW+1] == 1'b0) && (r_e >= E_MAX);
    assign w_unf = (r_e[EW+1] == 1'b1) || (r_e == {(EW+2){1'b0}});

    // Operands are only taken in IDLE, and never while reset is asserted.
    assign in_ready = (r_state == S_IDLE) && !rst;

    assign out_valid = r_out_valid;
    assign out_e     = r_out_e;
    assign out_m     = r_out_m;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;
    assign out_unf   = r_out_unf;

    // Control FSM, normalisation datapath and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_m         <= {PW{1'b0}};
            r_e         <= {(EW+2){1'b0}};
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_e     <= {EW{1'b0}};
            r_out_m     <= {PW{1'b0}};
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m     <= in_m;
                        r_e     <= {2'b00, in_e};
                        r_zero  <= 1'b0;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_m == {PW{1'b0}}) begin
                        r_zero  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_m[PW-1] == 1'b1) begin
                        // Right shift by one; the dropped bit folds into bit0.
                        r_m     <= {1'b0, r_m[PW-1:2], r_m[1] | r_m[0]};
                        r_e     <= r_e + {{(EW+1){1'b0}}, 1'b1};
                        r_state <= S_DONE;
                    end else if (r_m[PW-2] == 1'b1) begin
                        r_state <= S_DONE;
                    end else begin
                        r_m <= r_m << w_k;
                        r_e <= r_e - w_k_ext;
                    end
                end
                S_DONE: begin
                    // The first DONE cycle loads the result; afterwards it is
                    // held until the downstream handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_zero  <= 1'b0;
                        r_out_ovf   <= 1'b0;
                        r_out_unf   <= 1'b0;
                        r_out_m     <= r_m;
                        if (r_zero) begin
                            r_out_m    <= {PW{1'b0}};
                            r_out_e    <= {EW{1'b0}};
                            r_out_zero <= 1'b1;
                        end else if (w_ovf) begin
                            r_out_e   <= {EW{1'b1}};
                            r_out_ovf <= 1'b1;
                        end else if (w_unf) begin
                            r_out_e   <= {EW{1'b0}};
                            r_out_unf <= 1'b1;
                        end else begin
                            r_out_e <= r_e[EW-1:0];
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_norm_seq.md
Name: mul_norm_seq

Overview:
- Parametrised, multi-cycle normaliser for the floating-point multiplier datapath.
- Takes the raw 2*MW-bit mantissa product and the biased exponent sum; returns a product whose leading one sits at bit 2*MW-2, with the exponent adjusted to match.
- Left shifts are applied iteratively, up to SHIFT_STEP bits per cycle, to bound shifter area.
- Sits between the mantissa multiplier and the rounder; valid/ready handshakes on both sides.

Parameters:
MW, 24, significand width incl. hidden bit; product width PW = 2*MW
EW, 8, exponent width
SHIFT_STEP, 4, max left-shift positions per NORM cycle (1..PW-2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand
in_e  input  EW  biased exponent sum (unsigned)
in_m  input  PW  raw mantissa product
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_e  output  EW  adjusted exponent
out_m  output  PW  normalised mantissa, leading one at bit PW-2
out_zero  output  1  product was zero
out_ovf  output  1  exponent overflow
out_unf  output  1  exponent underflow

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst is sampled on the clk rising edge only; rst high forces state IDLE.
  - Reset values: out_valid=0, out_e=0, out_m=0, all flags 0, internal m/e cleared.
  - in_ready=0 while rst is high.
  - Reset mid-operation abandons the operand; no output is produced for it.
- Internal exponent e is signed, EW+2 bits; in_e is zero-extended on capture.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture m<=in_m, e<=in_e, then go to NORM.
- NORM (in_ready=0). Priority, evaluated each cycle:
  1. m==0: go to DONE with zero=1.
  2. m[PW-1]==1: m <= (m>>1) with new bit0 = old m[1] | old m[0] (sticky); e<=e+1; go to DONE.
  3. m[PW-2]==1: go to DONE unchanged.
  4. Otherwise: lz = number of zeros above the leading one, counted from bit PW-2 downward; k = min(lz, SHIFT_STEP); m <= m<<k; e <= e-k; stay in NORM.
- DONE
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE.
  - in_ready rises the cycle after the handshake; no overlap between operands.
- Output mapping (registered on entry to DONE):
  - zero: out_m=0, out_e=0, out_zero=1, other flags 0.
  - e >= 2^EW-1: out_ovf=1, out_e = all ones, out_m still normalised.
  - e <= 0: out_unf=1, out_e=0, out_m still normalised; no denormal shifting.
  - Otherwise out_e = e[EW-1:0].
- Latency
  - Accept edge to out_valid: 2 + ceil(lz/SHIFT_STEP) cycles, where lz is the leading-zero count defined in step 4.
  - Cases 1, 2 and 3 take 2 cycles.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.
- Throughput: at most one operand per (latency + 1) cycles.

Test Plan (MW=24, EW=8, SHIFT_STEP=4, PW=48):
1. in_m=0x800000000001, in_e=127 -> out_m=0x400000000001 (sticky), out_e=128, no flags, out_valid 2 cycles after accept.
2. in_m=0x400000000000, in_e=100 -> out_m unchanged, out_e=100, latency 2; hold out_ready=0 for 3 cycles -> outputs stable, in_ready stays 0 until the cycle after the handshake.
3. in_m=0x000000000001, in_e=100 -> lz=46, 12 shift cycles, out_m=0x400000000000, out_e=54, latency 14.
4. in_m=0, in_e=90 -> out_zero=1, out_e=0, out_m=0, latency 2.
5. Flag cases:
   - in_m=0x000000000001, in_e=20 -> e=-26, out_unf=1, out_e=0, out_m=0x400000000000.
   - in_m=0x800000000000, in_e=254 -> out_ovf=1, out_e=0xFF.
6. Assert rst for 1 cycle during NORM of scenario 3 -> next cycle IDLE, out_valid=0, in_ready=1; a fresh operand then completes correctly.
